// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback and the multi-cycle multiply/divide unit. It tracks the multdiv
//   destination in a one-entry scoreboard and buffers a multdiv result that
//   collides with a pipeline write. A multdiv exception becomes a status write
//   to r30. The write port is driven from registers.
//
// Ports
//   clock, reset                  rising-edge clock, async active-low reset
//   pl_valid/pl_reg/pl_data       pipeline writeback request
//   pl_ready                      pipeline write accepted (0 = pipeline holds)
//   md_start/md_op/md_dest        multdiv issue (op: 0 = mult, 1 = div)
//   md_rdy/md_exception/md_result multdiv completion pulse, exception, result
//   rs_addr/rt_addr               decode-stage source registers
//   md_busy                       multdiv operation outstanding
//   md_hazard                     decode must stall (RAW/WAW on multdiv dest)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg  registered regfile write port
module regfile_write_arbiter #(
  parameter int unsigned MAX_WAIT    = 2,
  parameter int unsigned WAIT_W      = 2,
  parameter int unsigned RSTATUS_MUL = 4,
  parameter int unsigned RSTATUS_DIV = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pl_valid,
  input  logic [4:0]  pl_reg,
  input  logic [31:0] pl_data,
  output logic        pl_ready,
  input  logic        md_start,
  input  logic        md_op,
  input  logic [4:0]  md_dest,
  input  logic        md_rdy,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        md_busy,
  output logic        md_hazard,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [4:0]        STATUS_REG = 5'd30;
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [4:0]        dest_q;
  logic              op_q;
  logic [4:0]        pend_reg_q;
  logic [31:0]       pend_data_q;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              grant;
  logic [4:0]        grant_reg;
  logic [31:0]       grant_data;
  logic              pend_load;
  logic [4:0]        md_reg;
  logic [31:0]       md_data;

  // Exception redirect is resolved before buffering, so the pending entry
  // already holds the final target and data.
  always_comb begin
    md_reg  = dest_q;
    md_data = md_result;
    if (md_exception) begin
      md_reg  = STATUS_REG;
      md_data = op_q ? 32'(RSTATUS_DIV) : 32'(RSTATUS_MUL);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    pl_ready   = 1'b1;
    grant      = 1'b0;
    grant_reg  = pl_reg;
    grant_data = pl_data;
    pend_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant = pl_valid;
        if (md_start) state_d = BUSY;
      end
      BUSY: begin
        if (md_rdy && !pl_valid) begin
          grant      = 1'b1;
          grant_reg  = md_reg;
          grant_data = md_data;
          state_d    = IDLE;
        end else begin
          grant = pl_valid;
          if (md_rdy) begin
            pend_load = 1'b1;
            wait_d    = '0;
            state_d   = PEND;
          end
        end
      end
      PEND: begin
        if (pl_valid && wait_q < WAIT_MAX) begin
          grant  = 1'b1;
          wait_d = wait_q + 1'b1;
        end else begin
          // Drain the buffer; if the pipeline is also writing it is held off
          // for this one cycle and granted from IDLE next cycle.
          pl_ready   = !pl_valid;
          grant      = 1'b1;
          grant_reg  = pend_reg_q;
          grant_data = pend_data_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      op_q        <= 1'b0;
      pend_reg_q  <= '0;
      pend_data_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == IDLE && md_start) begin
        dest_q <= md_dest;
        op_q   <= md_op;
      end
      if (pend_load) begin
        pend_reg_q  <= md_reg;
        pend_data_q <= md_data;
      end
    end
  end

  // Writes to r0 are dropped here; the requester still sees its grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= grant && (grant_reg != '0);
      if (grant && (grant_reg != '0)) begin
        ctrl_writeReg <= grant_reg;
        data_writeReg <= grant_data;
      end
    end
  end

  assign md_busy   = (state_q != IDLE);
  assign md_hazard = md_busy && (dest_q != '0) &&
                     ((rs_addr == dest_q) || (rt_addr == dest_q) ||
                      (pl_valid && (pl_reg == dest_q)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pl_valid = 1'b0;
  logic [4:0]  pl_reg = '0;
  logic [31:0] pl_data = '0;
  logic        pl_ready;
  logic        md_start = 1'b0;
  logic        md_op = 1'b0;
  logic [4:0]  md_dest = '0;
  logic        md_rdy = 1'b0;
  logic        md_exception = 1'b0;
  logic [31:0] md_result = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        md_busy;
  logic        md_hazard;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  regfile_write_arbiter #(
    .MAX_WAIT(2),
    .WAIT_W(2),
    .RSTATUS_MUL(4),
    .RSTATUS_DIV(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pl_valid(pl_valid),
    .pl_reg(pl_reg),
    .pl_data(pl_data),
    .pl_ready(pl_ready),
    .md_start(md_start),
    .md_op(md_op),
    .md_dest(md_dest),
    .md_rdy(md_rdy),
    .md_exception(md_exception),
    .md_result(md_result),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .md_busy(md_busy),
    .md_hazard(md_hazard),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pv;
    logic [4:0]  preg;
    logic [31:0] pdata;
    logic        ms;
    logic        mop;
    logic [4:0]  mdest;
    logic        mrdy;
    logic        mexc;
    logic [31:0] mres;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        erdy;
    logic        ebusy;
    logic        ehaz;
    logic        ewe;
    logic [4:0]  ereg;
    logic [31:0] edata;
  } vec_t;

  int unsigned passed = 0;
  int unsigned total  = 0;
  vec_t tbl[$];
  vec_t seq[$];

  function automatic vec_t v(
    input logic pv, input logic [4:0] preg, input logic [31:0] pdata,
    input logic ms, input logic mop, input logic [4:0] mdest,
    input logic mrdy, input logic mexc, input logic [31:0] mres,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic erdy, input logic ebusy, input logic ehaz,
    input logic ewe, input logic [4:0] ereg, input logic [31:0] edata);
    vec_t r;
    r.pv = pv; r.preg = preg; r.pdata = pdata;
    r.ms = ms; r.mop = mop; r.mdest = mdest;
    r.mrdy = mrdy; r.mexc = mexc; r.mres = mres;
    r.rs = rs; r.rt = rt;
    r.erdy = erdy; r.ebusy = ebusy; r.ehaz = ehaz;
    r.ewe = ewe; r.ereg = ereg; r.edata = edata;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle: drive at negedge, check combinational outputs before the
  // rising edge, then the registered write port just after it.
  task automatic apply(input string tag, input int unsigned idx, input vec_t x);
    @(negedge clock);
    pl_valid = x.pv; pl_reg = x.preg; pl_data = x.pdata;
    md_start = x.ms; md_op = x.mop; md_dest = x.mdest;
    md_rdy = x.mrdy; md_exception = x.mexc; md_result = x.mres;
    rs_addr = x.rs; rt_addr = x.rt;
    #1;
    check($sformatf("%s[%0d] rdy/busy/haz", tag, idx),
          64'({pl_ready, md_busy, md_hazard}), 64'({x.erdy, x.ebusy, x.ehaz}));
    @(posedge clock);
    #1;
    check($sformatf("%s[%0d] we/reg/data", tag, idx),
          64'({ctrl_writeEnable, ctrl_writeReg, data_writeReg}),
          64'({x.ewe, x.ereg, x.edata}));
  endtask

  initial begin
    //             pv preg pdata         ms op dst rdy exc mres          rs rt  rdy bsy hz we reg data
    // Clean mult to r7, hazard window on rs=7
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             7, 0,  1, 0, 0, 0, 0,  0));
    tbl.push_back(v(0, 0, 0,             1, 0, 7,  0, 0, 0,             7, 0,  1, 0, 0, 0, 0,  0));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             7, 0,  1, 1, 1, 0, 0,  0));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             7, 0,  1, 1, 1, 0, 0,  0));
    tbl.push_back(v(1, 2, 32'hAA,        0, 0, 0,  0, 0, 0,             0, 0,  1, 1, 0, 1, 2,  32'hAA));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             7, 0,  1, 1, 1, 0, 2,  32'hAA));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  1, 0, 32'h30,        7, 0,  1, 1, 1, 1, 7,  32'h30));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             7, 0,  1, 0, 0, 0, 7,  32'h30));
    // Collision: WAW hazard, then r3 granted while r9 result is buffered
    tbl.push_back(v(0, 0, 0,             1, 0, 9,  0, 0, 0,             0, 0,  1, 0, 0, 0, 7,  32'h30));
    tbl.push_back(v(1, 9, 32'h99,        0, 0, 0,  0, 0, 0,             0, 0,  1, 1, 1, 1, 9,  32'h99));
    tbl.push_back(v(1, 3, 32'h11,        0, 0, 0,  1, 0, 32'h55,        0, 0,  1, 1, 0, 1, 3,  32'h11));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             0, 9,  1, 1, 1, 1, 9,  32'h55));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             0, 9,  1, 0, 0, 0, 9,  32'h55));
    // Starvation with MAX_WAIT=2
    tbl.push_back(v(0, 0, 0,             1, 0, 9,  0, 0, 0,             0, 0,  1, 0, 0, 0, 9,  32'h55));
    tbl.push_back(v(1, 1, 32'h101,       0, 0, 0,  1, 0, 32'h77,        0, 0,  1, 1, 0, 1, 1,  32'h101));
    tbl.push_back(v(1, 2, 32'h102,       0, 0, 0,  0, 0, 0,             0, 0,  1, 1, 0, 1, 2,  32'h102));
    tbl.push_back(v(1, 3, 32'h103,       0, 0, 0,  0, 0, 0,             0, 0,  1, 1, 0, 1, 3,  32'h103));
    tbl.push_back(v(1, 4, 32'h104,       0, 0, 0,  0, 0, 0,             0, 0,  0, 1, 0, 1, 9,  32'h77));
    tbl.push_back(v(1, 4, 32'h104,       0, 0, 0,  0, 0, 0,             0, 0,  1, 0, 0, 1, 4,  32'h104));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             0, 0,  1, 0, 0, 0, 4,  32'h104));
    // Div exception: r4 target redirected to r30 with code 5
    tbl.push_back(v(0, 0, 0,             1, 1, 4,  0, 0, 0,             0, 0,  1, 0, 0, 0, 4,  32'h104));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             4, 0,  1, 1, 1, 0, 4,  32'h104));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  1, 1, 32'hDEAD,      4, 0,  1, 1, 1, 1, 30, 32'h5));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             4, 0,  1, 0, 0, 0, 30, 32'h5));
    // Mult exception buffered behind a pipeline write; hazard still on r12
    tbl.push_back(v(0, 0, 0,             1, 0, 12, 0, 0, 0,             0, 0,  1, 0, 0, 0, 30, 32'h5));
    tbl.push_back(v(1, 5, 32'h55AA,      0, 0, 0,  1, 1, 32'h1,         0, 0,  1, 1, 0, 1, 5,  32'h55AA));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             12, 0, 1, 1, 1, 1, 30, 32'h4));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             0, 0,  1, 0, 0, 0, 30, 32'h4));
    // r0 targets from both sources are dropped; no hazard on r0
    tbl.push_back(v(1, 0, 32'hFFFFFFFF,  0, 0, 0,  0, 0, 0,             0, 0,  1, 0, 0, 0, 30, 32'h4));
    tbl.push_back(v(0, 0, 0,             1, 0, 0,  0, 0, 0,             0, 0,  1, 0, 0, 0, 30, 32'h4));
    tbl.push_back(v(1, 0, 32'hFFFFFFFF,  0, 0, 0,  0, 0, 0,             0, 0,  1, 1, 0, 0, 30, 32'h4));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  1, 0, 32'h1234,      0, 0,  1, 1, 0, 0, 30, 32'h4));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             0, 0,  1, 0, 0, 0, 30, 32'h4));
    // md_rdy ignored in IDLE; md_start ignored in BUSY
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  1, 0, 32'hBAD,       0, 0,  1, 0, 0, 0, 30, 32'h4));
    tbl.push_back(v(0, 0, 0,             1, 0, 6,  0, 0, 0,             0, 0,  1, 0, 0, 0, 30, 32'h4));
    tbl.push_back(v(0, 0, 0,             1, 0, 8,  0, 0, 0,             6, 0,  1, 1, 1, 0, 30, 32'h4));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  1, 0, 32'h66,        8, 0,  1, 1, 0, 1, 6,  32'h66));
    tbl.push_back(v(0, 0, 0,             0, 0, 0,  0, 0, 0,             0, 0,  1, 0, 0, 0, 6,  32'h66));

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset we/reg/data/busy",
          64'({ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_busy}), 64'(0));
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[i]) apply("tbl", i, tbl[i]);

    // Wait counter is cleared on each entry to PEND
    seq.push_back(v(0, 0, 0,   1, 0, 13, 0, 0, 0,      0, 0,  1, 0, 0, 0, 6,  32'h66));
    seq.push_back(v(1, 1, 1,   0, 0, 0,  1, 0, 32'hA1, 0, 0,  1, 1, 0, 1, 1,  32'h1));
    seq.push_back(v(1, 2, 2,   0, 0, 0,  0, 0, 0,      0, 0,  1, 1, 0, 1, 2,  32'h2));
    seq.push_back(v(0, 0, 0,   0, 0, 0,  0, 0, 0,      0, 0,  1, 1, 0, 1, 13, 32'hA1));
    seq.push_back(v(0, 0, 0,   1, 0, 14, 0, 0, 0,      0, 0,  1, 0, 0, 0, 13, 32'hA1));
    seq.push_back(v(1, 3, 3,   0, 0, 0,  1, 0, 32'hA2, 0, 0,  1, 1, 0, 1, 3,  32'h3));
    seq.push_back(v(1, 4, 4,   0, 0, 0,  0, 0, 0,      0, 0,  1, 1, 0, 1, 4,  32'h4));
    seq.push_back(v(1, 5, 5,   0, 0, 0,  0, 0, 0,      0, 0,  1, 1, 0, 1, 5,  32'h5));
    seq.push_back(v(1, 6, 6,   0, 0, 0,  0, 0, 0,      0, 0,  0, 1, 0, 1, 14, 32'hA2));
    seq.push_back(v(1, 6, 6,   0, 0, 0,  0, 0, 0,      0, 0,  1, 0, 0, 1, 6,  32'h6));
    foreach (seq[i]) apply("cnt", i, seq[i]);

    // Reset while a result is buffered in PEND
    apply("rst", 0, v(0, 0, 0,        1, 0, 10, 0, 0, 0,      0, 0, 1, 0, 0, 0, 6,  32'h6));
    apply("rst", 1, v(1, 11, 32'h11,  0, 0, 0,  1, 0, 32'hCC, 0, 0, 1, 1, 0, 1, 11, 32'h11));
    @(negedge clock);
    pl_valid = 1'b0; md_rdy = 1'b0; md_start = 1'b0;
    reset = 1'b0;
    #1;
    check("rst async we/reg/data/busy",
          64'({ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_busy}), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    for (int unsigned i = 2; i < 5; i++)
      apply("rst", i, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback and the multi-cycle multiply/divide unit.
- Keeps a one-entry scoreboard for the multdiv destination register and buffers a completed multdiv result when the port is busy.
- Converts multdiv overflow or divide-by-zero into a status write to r30.
- Sits after the writeback mux and drives the regfile write port through registers.

Parameters:
- MAX_WAIT, 2: consecutive pipeline-write cycles a buffered multdiv result may wait before the pipeline is stalled.
- WAIT_W, 2: width of the wait counter; must hold MAX_WAIT.
- RSTATUS_MUL, 4: r30 code written on a mult exception.
- RSTATUS_DIV, 5: r30 code written on a div exception.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- pl_valid  in  1  pipeline writeback request this cycle.
- pl_reg  in  5  pipeline destination register.
- pl_data  in  32  pipeline write data.
- pl_ready  out  1  pipeline write accepted; 0 means the pipeline must hold.
- md_start  in  1  multdiv operation issued.
- md_op  in  1  0 = mult, 1 = div.
- md_dest  in  5  multdiv destination register.
- md_rdy  in  1  one-cycle pulse: multdiv result valid.
- md_exception  in  1  qualifies md_rdy: overflow or divide-by-zero.
- md_result  in  32  multdiv result.
- rs_addr  in  5  decode-stage source register A.
- rt_addr  in  5  decode-stage source register B.
- md_busy  out  1  state != IDLE.
- md_hazard  out  1  decode must stall.
- ctrl_writeEnable  out  1  regfile write enable (registered).
- ctrl_writeReg  out  5  regfile write address (registered).
- data_writeReg  out  32  regfile write data (registered).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; scoreboard dest, op, pending data and wait counter all cleared.
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - Reset mid-operation discards the in-flight or buffered multdiv result.
- Write port:
  - Outputs are registered; a write granted in cycle N appears on the port in cycle N+1, held for exactly one cycle.
  - With no grant, ctrl_writeEnable=0 and addr/data hold their last values.
- r0: any grant whose target is r0 is dropped (ctrl_writeEnable=0), but pl_ready still accepts it.
- Multdiv target:
  - md_exception=0: target = captured dest, data = md_result.
  - md_exception=1: target = 30, data = RSTATUS_MUL or RSTATUS_DIV, chosen by the captured op.
- State IDLE:
  - md_start=1 captures md_dest and md_op and moves to BUSY.
  - md_rdy is ignored.
  - pl_ready=1.
- State BUSY:
  - md_start is ignored (issue logic stalls on md_busy).
  - md_rdy=1 and pl_valid=0: grant the multdiv write, go to IDLE.
  - md_rdy=1 and pl_valid=1: grant the pipeline, latch the multdiv write into the pending buffer, wait counter=0, go to PEND.
  - pl_ready=1.
- State PEND:
  - pl_valid=0: grant the pending write, go to IDLE, pl_ready=1.
  - pl_valid=1 and counter < MAX_WAIT: grant the pipeline, counter+1, pl_ready=1.
  - pl_valid=1 and counter == MAX_WAIT: pl_ready=0, grant the pending write, go to IDLE. The held pipeline write is granted the next cycle.
- Priority: only one write is granted per cycle. pl_ready is combinational from state, counter and pl_valid.
- md_hazard (combinational):
  - Asserted when state != IDLE, dest != 0, and any of: rs_addr==dest, rt_addr==dest, or (pl_valid and pl_reg==dest) (WAW).
  - Deasserts in the cycle after the multdiv write is granted, i.e. the cycle state reads IDLE.
  - Comparison uses the captured dest even when an exception redirects the write to r30.
- Wait counter: saturates at MAX_WAIT; cleared on entry to PEND.

Test Plan:
- Reset mid-PEND:
  - Stimulus: reset low for 1 cycle while in PEND.
  - Required: all port outputs 0, md_busy=0; the pending result is never written.
- Clean multdiv:
  - Stimulus: md_start with md_dest=7, md_op=0; 5 cycles later md_rdy with md_result=0x0000_0030, pl_valid=0.
  - Required: next cycle we=1, reg=7, data=0x30; md_hazard high for rs_addr=7 from the cycle after start until write grant.
- Collision:
  - Stimulus: md_rdy with result 0x55 for r9 while pl_valid writes r3=0x11, then pl_valid=0.
  - Required: port shows r3=0x11, then r9=0x55; pl_ready stays 1.
- Starvation:
  - Stimulus: pending r9 result, pl_valid held high with MAX_WAIT=2.
  - Required: two pipeline writes granted, third cycle pl_ready=0 and r9 written, then the held pipeline write.
- Div exception:
  - Stimulus: md_op=1, md_dest=4, md_rdy with md_exception=1.
  - Required: write reg=30, data=5; r4 unchanged.
- r0 targets:
  - Stimulus: pipeline pl_reg=0, data 0xFFFF_FFFF; separately md_dest=0.
  - Required: ctrl_writeEnable stays 0; pl_ready=1; md_hazard never asserts for rs_addr=0.
